// File: rtl/capture_unpacker_if.sv
// Stream bundle for the capture unpacker: packed-word input side and
// per-sample output side, both valid/ready.
interface capture_unpacker_if #(
    parameter int CHANNELS = 32,
    parameter int DEPTH    = 8
);
    logic [CHANNELS*DEPTH-1:0] in_word;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS-1:0]       out_sample;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_sample, out_valid, out_last
    );

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_sample, out_valid, out_last
    );
endinterface

// File: rtl/capture_unpacker.sv
// Re-serialises packed capture words (CHANNELS lanes x DEPTH bits) into DEPTH
// per-sample CHANNELS-bit vectors, oldest sample first, over valid/ready.
module capture_unpacker #(
    parameter int CHANNELS = 32,
    parameter int DEPTH    = 8,
    parameter int WCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WCNT_W-1:0] cfg_words,
    capture_unpacker_if.slave bus,
    output logic              busy,
    output logic              done
);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                    r_state;
    logic [WCNT_W-1:0]         r_words_tot;
    logic [WCNT_W-1:0]         r_words_in;
    logic [WCNT_W-1:0]         r_words_out;
    logic [CHANNELS*DEPTH-1:0] r_buf;
    logic                      r_buf_valid;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_done;

    logic                      w_run;
    logic                      w_idx_last;
    logic                      w_out_fire;
    logic                      w_in_ready;
    logic                      w_in_fire;
    logic                      w_out_last;
    logic [IDX_W-1:0]          w_rev_idx;
    logic [DEPTH-1:0]          w_lane [CHANNELS];
    logic [CHANNELS-1:0]       w_sample;

    assign w_run      = (r_state == S_RUN);
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_out_fire = r_buf_valid && bus.out_ready;
    // Refill on the very cycle the last sample leaves, so word boundaries cost no bubble.
    assign w_in_ready = w_run && (r_words_in < r_words_tot) &&
                        (!r_buf_valid || (w_out_fire && w_idx_last));
    assign w_in_fire  = w_in_ready && bus.in_valid;
    assign w_out_last = r_buf_valid && w_idx_last &&
                        (r_words_out == r_words_tot - WCNT_W'(1));

    // Lane bit 0 is the newest capture, so the oldest sample sits at the lane MSB.
    assign w_rev_idx = IDX_LAST - r_idx;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign w_lane[c]   = r_buf[c*DEPTH +: DEPTH];
        assign w_sample[c] = w_lane[c][w_rev_idx];
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_buf_valid;
    assign bus.out_sample = w_sample;
    assign bus.out_last   = w_out_last;
    assign busy           = w_run;
    assign done           = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_words_tot <= '0;
            r_words_in  <= '0;
            r_words_out <= '0;
            // NOTE: the word buffer is cleared too, since out_sample is decoded from it and must read zero after reset.
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_words == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_words_tot <= cfg_words;
                            r_words_in  <= '0;
                            r_words_out <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_out_fire) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_idx_last) begin
                            r_words_out <= r_words_out + 1'b1;
                            if (!w_in_fire) begin
                                r_buf_valid <= 1'b0;
                            end
                        end
                        if (w_out_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    if (w_in_fire) begin
                        r_buf       <= bus.in_word;
                        r_buf_valid <= 1'b1;
                        r_words_in  <= r_words_in + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
